// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// cpu_bus_pkg: shared bus types for the CPU register-bus initiators and responders.
// Revision: 1.0
package cpu_bus_pkg;

  localparam int BUS_WIDTH = 32;

  typedef logic [BUS_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RD_RESP = 2'd2,
    WR_RESP = 2'd3
  } resp_state_e;

endpackage
`default_nettype wire

// File: rtl/resp_mem_array.sv
`default_nettype none
// resp_mem_array: word storage with one synchronous write port and one asynchronous read port.
// Revision: 1.0
module resp_mem_array
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  word_t                 wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output word_t                 rdata
);

  word_t mem [2**DEPTH_LOG2];

  // Contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/bus_mem_responder.sv
`default_nettype none
// bus_mem_responder: windowed memory responder on the CPU register bus with wait states
// and a ready/release handshake. Revision: 1.0
module bus_mem_responder
  import cpu_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_LOG2  = 8,
  parameter int          WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr_bus,
  inout  wire  [BUS_WIDTH-1:0] data_bus,
  input  logic                 rd,
  input  logic                 wr,
  output logic                 ready,
  output logic                 err
);

  localparam int                CNT_W     = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  resp_state_e           state;
  logic [CNT_W-1:0]      count;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  op_rd;

  logic [32:0]           offset;
  logic                  hit;
  logic [DEPTH_LOG2-1:0] idx_in;
  logic                  accept;
  logic                  req_held;
  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  word_t                 rdata;

  // A 33-bit subtraction: bit 32 flags addresses below the base, the
  // remaining upper bits flag addresses at or beyond the window end.
  assign offset   = {1'b0, addr_bus} - {1'b0, ADDR_BASE};
  assign hit      = !offset[32] && (offset[31:DEPTH_LOG2] == '0);
  assign idx_in   = offset[DEPTH_LOG2-1:0];
  assign accept   = (state == IDLE) && hit && (rd ^ wr);
  assign req_held = op_rd ? rd : wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      err   <= 1'b0;
      idx   <= '0;
      op_rd <= 1'b0;
    end else begin
      err <= (state == IDLE) && hit && rd && wr;
      case (state)
        IDLE: begin
          if (accept) begin
            idx   <= idx_in;
            op_rd <= rd;
            count <= WAIT_INIT;
            if (WAIT_STATES == 0) begin
              state <= rd ? RD_RESP : WR_RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (count != '0) begin
            count <= count - CNT_ONE;
          end
          if (!req_held) begin
            state <= IDLE;
          end else if (count <= CNT_ONE) begin
            state <= op_rd ? RD_RESP : WR_RESP;
          end
        end
        RD_RESP: begin
          if (!rd) begin
            state <= IDLE;
          end
        end
        WR_RESP: begin
          if (!wr) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The single write lands on the edge that enters WR_RESP.
  assign we = !rst && wr &&
              ((accept && !rd && (WAIT_STATES == 0)) ||
               ((state == WAIT) && !op_rd && (count <= CNT_ONE)));
  assign waddr = (state == IDLE) ? idx_in : idx;

  resp_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(data_bus),
    .raddr(idx),
    .rdata(rdata)
  );

  assign ready    = (state == RD_RESP) || (state == WR_RESP);
  assign data_bus = (state == RD_RESP) ? rdata : {BUS_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
`default_nettype none
// tb_bus_mem_responder: directed checks of the memory responder, two wait-state configurations.
// Revision: 1.0
module tb_bus_mem_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] drv = '0;
  logic        oe = 1'b0;
  wire  [31:0] data_bus;
  logic        ready, err;

  logic [31:0] addr0 = '0;
  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] drv0 = '0;
  logic        oe0 = 1'b0;
  wire  [31:0] data_bus0;
  logic        ready0, err0;

  int checks = 0;
  int errors = 0;
  logic [31:0] zw;

  assign data_bus  = oe  ? drv  : 32'bz;
  assign data_bus0 = oe0 ? drv0 : 32'bz;

  always #5 clk = ~clk;

  bus_mem_responder #(.ADDR_BASE(BASE), .DEPTH_LOG2(8), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .addr_bus(addr), .data_bus(data_bus),
    .rd(rd), .wr(wr), .ready(ready), .err(err)
  );

  bus_mem_responder #(.ADDR_BASE(32'h0), .DEPTH_LOG2(4), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .addr_bus(addr0), .data_bus(data_bus0),
    .rd(rd0), .wr(wr0), .ready(ready0), .err(err0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transfer on the main instance; a2 replaces the address after acceptance.
  task automatic xfer(input bit is_rd, input logic [31:0] a, input logic [31:0] a2,
                      input logic [31:0] d, output int lat, output logic [31:0] q);
    addr = a;
    if (is_rd) rd = 1'b1;
    else begin
      wr = 1'b1; drv = d; oe = 1'b1;
    end
    lat = 0;
    do begin
      tick;
      lat++;
      if (lat == 1) addr = a2;
    end while (!ready && lat < 20);
    q = data_bus;
    rd = 1'b0; wr = 1'b0; oe = 1'b0;
    tick;
    chk("release_ready", {31'b0, ready}, 32'd0);
    chk("release_bus", data_bus, zw);
  endtask

  initial begin
    int          lat;
    logic [31:0] q;
    logic        bad;
    zw = 32'bz;

    // Reset then idle
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_ready", {31'b0, ready}, 32'd0);
      chk("idle_err", {31'b0, err}, 32'd0);
      chk("idle_bus", data_bus, zw);
    end

    // Write then read back at BASE+5
    xfer(1'b0, BASE + 5, BASE + 5, 32'd123, lat, q);
    chk("wr_latency", lat, 32'd3);
    xfer(1'b1, BASE + 5, BASE + 5, 32'd0, lat, q);
    chk("rd_latency", lat, 32'd3);
    chk("rd_data_5", q, 32'd123);

    // Window boundaries; second read changes the address after acceptance
    xfer(1'b0, BASE + 0, BASE + 0, 32'd321, lat, q);
    xfer(1'b0, BASE + 255, BASE + 255, 32'd123, lat, q);
    xfer(1'b1, BASE + 0, BASE + 0, 32'd0, lat, q);
    chk("rd_data_0", q, 32'd321);
    xfer(1'b1, BASE + 255, BASE + 0, 32'd0, lat, q);
    chk("rd_data_255", q, 32'd123);

    addr = BASE + 256; rd = 1'b1; bad = 1'b0;
    repeat (10) begin
      tick;
      if (ready !== 1'b0 || err !== 1'b0 || data_bus !== zw) bad = 1'b1;
    end
    chk("miss_above", {31'b0, bad}, 32'd0);
    addr = BASE - 1; bad = 1'b0;
    repeat (5) begin
      tick;
      if (ready !== 1'b0 || err !== 1'b0 || data_bus !== zw) bad = 1'b1;
    end
    chk("miss_below", {31'b0, bad}, 32'd0);
    rd = 1'b0;
    tick;

    // Illegal rd & wr together
    xfer(1'b0, BASE + 7, BASE + 7, 32'h0000_AAAA, lat, q);
    addr = BASE + 7; rd = 1'b1; wr = 1'b1; drv = 32'h0000_5555; oe = 1'b1;
    tick;
    chk("err_pulse", {31'b0, err}, 32'd1);
    chk("err_no_ready", {31'b0, ready}, 32'd0);
    rd = 1'b0; wr = 1'b0; oe = 1'b0;
    tick;
    chk("err_clear", {31'b0, err}, 32'd0);
    xfer(1'b1, BASE + 7, BASE + 7, 32'd0, lat, q);
    chk("err_mem_kept", q, 32'h0000_AAAA);

    // Write aborted during the wait states
    xfer(1'b0, BASE + 9, BASE + 9, 32'h0000_0077, lat, q);
    addr = BASE + 9; wr = 1'b1; drv = 32'd999; oe = 1'b1;
    tick;
    wr = 1'b0; oe = 1'b0; bad = 1'b0;
    repeat (4) begin
      tick;
      if (ready !== 1'b0) bad = 1'b1;
    end
    chk("abort_no_ready", {31'b0, bad}, 32'd0);
    xfer(1'b1, BASE + 9, BASE + 9, 32'd0, lat, q);
    chk("abort_mem_kept", q, 32'h0000_0077);

    // Reset during RD_RESP
    addr = BASE + 5; rd = 1'b1; lat = 0;
    do begin
      tick;
      lat++;
    end while (!ready && lat < 20);
    chk("pre_rst_bus", data_bus, 32'd123);
    rst = 1'b1;
    tick;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_bus", data_bus, zw);
    rst = 1'b0; rd = 1'b0;
    tick;
    chk("post_rst_ready", {31'b0, ready}, 32'd0);

    // Zero wait states
    addr0 = 32'd3; wr0 = 1'b1; drv0 = 32'h0000_BEEF; oe0 = 1'b1;
    tick;
    chk("ws0_wr_ready", {31'b0, ready0}, 32'd1);
    wr0 = 1'b0; oe0 = 1'b0;
    tick;
    chk("ws0_wr_release", {31'b0, ready0}, 32'd0);
    rd0 = 1'b1;
    tick;
    chk("ws0_rd_ready", {31'b0, ready0}, 32'd1);
    chk("ws0_rd_data", data_bus0, 32'h0000_BEEF);
    rd0 = 1'b0;
    tick;
    chk("ws0_rd_release", data_bus0, zw);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
